multi_phase_traffic_ctrl: RTL

Parametrised N-phase intersection controller: sequences any number of conflicting approaches through green, optional flicker, yellow and all-red clearance, with demand-driven phase skipping. It has an embedded tick-driven interval timer, so no external timer handshake is needed. It sits between the system time-base strobe and the lamp drivers, one lamp pair per phase.

---
 rtl/traffic_pkg.sv | 43 ++++
 rtl/multi_phase_traffic_ctrl_phase_timer.sv | 29 ++
 rtl/multi_phase_traffic_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types and next-phase selection for the multi-phase traffic controller.
// ST_FLICKER exists only when TRAFFIC_FLICKER_EN is defined.
package traffic_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'b00,
        RED    = 2'b01,
        YELLOW = 2'b10,
        GREEN  = 2'b11
    } lamp_t;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_ALL_RED = 3'd1,
        ST_GREEN   = 3'd2,
`ifdef TRAFFIC_FLICKER_EN
        ST_FLICKER = 3'd3,
`endif
        ST_YELLOW  = 3'd4
    } ctrl_state_t;

    localparam int MAX_PHASES = 8;

    // First requesting index above cur (wrapping, cur itself last); plain round robin when idle.
    function automatic logic [2:0] next_phase(input logic [MAX_PHASES-1:0] req,
                                              input logic [2:0]            cur,
                                              input int                    n);
        logic [2:0] sel;
        logic       found;
        int         idx;
        sel   = (int'(cur) >= n - 1) ? 3'd0 : cur + 3'd1;
        found = 1'b0;
        for (int i = 1; i <= MAX_PHASES; i++) begin
            idx = (int'(cur) + i) % n;
            if (i <= n && !found && req[3'(idx)]) begin
                sel   = 3'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/multi_phase_traffic_ctrl_phase_timer.sv
// Tick-driven down-counter; loads duration-1 on state entry, expires on a tick at zero.
module phase_timer #(
    parameter int TW = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          tick,
    input  logic          clear,
    output logic          expire,
    output logic [TW-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && count != '0) begin
            count <= count - TW'(1);
        end
    end

    assign expire = tick && (count == '0);

endmodule

// File: rtl/multi_phase_traffic_ctrl.sv
// N-phase intersection controller: all-red, green, optional flicker, yellow per served phase.
// Flicker is compiled in only when TRAFFIC_FLICKER_EN is defined.
module multi_phase_traffic_ctrl
    import traffic_pkg::*;
#(
    parameter int            N_PHASES      = 4,
    parameter int            TW            = 6,
    parameter logic [TW-1:0] GREEN_DUR     = TW'(30),
    parameter logic [TW-1:0] YELLOW_DUR    = TW'(3),
    parameter logic [TW-1:0] RED_CLEAR     = TW'(2),
    parameter logic [TW-1:0] FLICKER_TICKS = TW'(4)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        tick,
    input  logic [N_PHASES-1:0]         req,
    output logic [2*N_PHASES-1:0]       L_out,
    output logic [$clog2(N_PHASES)-1:0] active_phase,
    output logic                        phase_done,
    output logic                        busy
);

    localparam int AW = $clog2(N_PHASES);

`ifdef TRAFFIC_FLICKER_EN
    localparam bit FLICKER_ON = 1'b1;
`else
    localparam bit FLICKER_ON = 1'b0;
`endif

    // Zero-length durations behave as one tick.
    localparam logic [TW-1:0] G_EFF   = (GREEN_DUR == '0) ? TW'(1) : GREEN_DUR;
    localparam logic [TW-1:0] Y_TICKS = (YELLOW_DUR == '0) ? TW'(1) : YELLOW_DUR;
    localparam logic [TW-1:0] R_TICKS = (RED_CLEAR == '0) ? TW'(1) : RED_CLEAR;
    localparam logic [TW-1:0] G_TICKS = !FLICKER_ON ? G_EFF :
                                        (FLICKER_TICKS >= G_EFF) ? TW'(1) : G_EFF - FLICKER_TICKS;
`ifdef TRAFFIC_FLICKER_EN
    localparam logic [TW-1:0] F_TICKS = (FLICKER_TICKS >= G_EFF) ? G_EFF - TW'(1) : FLICKER_TICKS;
`endif

    ctrl_state_t   state, state_next;
    logic          expire;
    logic          load;
    logic [TW-1:0] load_val;
    logic [TW-1:0] count;
    logic          first_serve;
    logic [2:0]    sel_base;
    lamp_t         served;

    phase_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
        .clear    (stop),
        .expire   (expire),
        .count    (count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_OFF;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (stop) begin
            state_next = ST_OFF;
        end else begin
            case (state)
                ST_OFF:     if (start)  state_next = ST_ALL_RED;
                ST_ALL_RED: if (expire) state_next = ST_GREEN;
`ifdef TRAFFIC_FLICKER_EN
                ST_GREEN:   if (expire) state_next = (F_TICKS != '0) ? ST_FLICKER : ST_YELLOW;
                ST_FLICKER: if (expire) state_next = ST_YELLOW;
`else
                ST_GREEN:   if (expire) state_next = ST_YELLOW;
`endif
                ST_YELLOW:  if (expire) state_next = ST_ALL_RED;
                default:    state_next = ST_OFF;
            endcase
        end
    end

    // Timer reloads on every entry into a timed state.
    always_comb begin
        load = (state_next != state) && (state_next != ST_OFF);
        case (state_next)
            ST_ALL_RED: load_val = R_TICKS - TW'(1);
            ST_GREEN:   load_val = G_TICKS - TW'(1);
`ifdef TRAFFIC_FLICKER_EN
            ST_FLICKER: load_val = F_TICKS - TW'(1);
`endif
            ST_YELLOW:  load_val = Y_TICKS - TW'(1);
            default:    load_val = '0;
        endcase
    end

    // After OFF, selection starts from the last phase so idle demand lands on phase 0.
    assign sel_base = first_serve ? 3'(N_PHASES - 1) : 3'(active_phase);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_phase <= '0;
            first_serve  <= 1'b1;
            phase_done   <= 1'b0;
        end else begin
            phase_done <= (state == ST_YELLOW) && (state_next == ST_ALL_RED);
            if (stop) begin
                active_phase <= '0;
                first_serve  <= 1'b1;
            end else if (state == ST_ALL_RED && expire) begin
                active_phase <= AW'(next_phase(8'(req), sel_base, N_PHASES));
                first_serve  <= 1'b0;
            end
        end
    end

`ifdef TRAFFIC_FLICKER_EN
    logic [TW-1:0] fl_elapsed;
    assign fl_elapsed = F_TICKS - TW'(1) - count;
`else
    logic unused_count;
    assign unused_count = ^count;
`endif

    always_comb begin
        case (state)
            ST_GREEN:   served = GREEN;
            ST_YELLOW:  served = YELLOW;
`ifdef TRAFFIC_FLICKER_EN
            ST_FLICKER: served = fl_elapsed[0] ? GREEN : OFF;
`endif
            default:    served = RED;
        endcase
        L_out = '0;
        for (int k = 0; k < N_PHASES; k++) begin
            case (state)
                ST_OFF:     L_out[2*k +: 2] = OFF;
                ST_ALL_RED: L_out[2*k +: 2] = RED;
                default:    L_out[2*k +: 2] = (k == int'(active_phase)) ? served : RED;
            endcase
        end
        busy = (state != ST_OFF);
    end

endmodule
